// File: rtl/uart_mmio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : uart_mmio                                                |
// | Description : Memory-mapped UART (8N1) with TXD/RXD/CON registers and  |
// |               a level interrupt for TX-complete and RX-data-ready.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module uart_mmio #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- decode
    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, rxd_rd, con_rd;

    assign sel_txd = (addr == BASE_ADDR);
    assign sel_rxd = (addr == BASE_ADDR + 32'd4);
    assign sel_con = (addr == BASE_ADDR + 32'd8);
    assign txd_wr  = wr & sel_txd;
    assign con_wr  = wr & sel_con;
    assign rxd_rd  = rd & sel_rxd;
    assign con_rd  = rd & sel_con;

    // Only the low byte of a TXD store and the low two bits of a CON store matter.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // ------------------------------------------------------------- registers
    logic       tx_irq_en, rx_irq_en;
    state_t     tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift, tx_byte;
    logic       tx_out, tx_busy, tx_done;

    logic       rx_meta, rx_s;
    state_t     rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift, rx_data;
    logic       rx_ready, rx_overrun, frame_err;

    // Interrupt enables: a CON store touches only bits 1:0.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
        end else if (con_wr) begin
            tx_irq_en <= wdata[0];
            rx_irq_en <= wdata[1];
        end
    end

    // Transmitter: start/data/stop bits each held for CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_byte  <= 8'd0;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            // Clears first so that a set in STOP on the same edge wins.
            if (txd_wr || con_rd)
                tx_done <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (txd_wr) begin
                        tx_state <= S_START;
                        tx_cnt   <= '0;
                        tx_bit   <= 3'd0;
                        tx_shift <= wdata[7:0];
                        tx_byte  <= wdata[7:0];
                        tx_out   <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_DATA;
                        tx_out   <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            tx_out   <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_out   <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_IDLE;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Two-flop synchroniser; resets to the idle line level so no false start follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver: confirm start at mid-bit, then sample every CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'd0;
            rx_data    <= 8'd0;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Clears first so that a set in STOP on the same edge wins.
            if (rxd_rd)
                rx_ready <= 1'b0;
            if (con_rd) begin
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= 3'd0;
                        rx_state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= S_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                        if (rx_s) begin
                            rx_data  <= rx_shift;
                            rx_ready <= 1'b1;
                            if (rx_ready)
                                rx_overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Load data mux; zero unless a load hits one of the three registers.
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (sel_txd)
                rdata = {24'd0, tx_byte};
            else if (sel_rxd)
                rdata = {24'd0, rx_data};
            else if (sel_con)
                rdata = {25'd0, frame_err, rx_overrun, tx_busy, rx_ready,
                         tx_done, rx_irq_en, tx_irq_en};
        end
    end

    assign uart_tx = tx_out;
    assign irq     = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready);

endmodule
`default_nettype wire

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART peripheral on the CPU's data bus, alongside the LED/7-seg/Systick devices, in the 0x4000_xxxx I/O window. The MEM stage issues loads and stores to it. It serialises bytes onto uart_tx, deserialises uart_rx, and raises irq for the CPU interrupt input. One start bit, 8 data bits LSB-first, one stop bit, no parity.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4
BASE_ADDR, 32'h4000_0018, byte address of TXD; RXD = BASE+4, CON = BASE+8

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
addr  in  32  bus byte address (MEM-stage ALU result)
wdata  in  32  store data
rd  in  1  load strobe
wr  in  1  store strobe
rdata  out  32  load data, combinational
uart_rx  in  1  serial input, asynchronous
uart_tx  out  1  serial output, idle high
irq  out  1  interrupt request

Behaviour:
- Reset: reset and clk are as stated in Ports (synchronous, active-high). uart_tx=1, irq=0, all registers and flags 0, both FSMs IDLE. Reset mid-frame aborts the frame: uart_tx is high after the next edge and partial RX data is discarded.
- Decode: only full-word addresses BASE, BASE+4 and BASE+8 are selected. Other addresses give rdata=0 and writes have no effect. rdata=0 whenever rd=0.
- TXD (write): wdata[7:0] starts a transmission if TX is IDLE. It is ignored if TX is busy. The write also clears tx_done. TXD reads return {24'b0, last tx byte}.
- RXD (read): {24'b0, rx_data}. A read with rd=1 clears rx_ready on that clock edge.
- CON bit layout:
  - bit0 tx_irq_en (RW)
  - bit1 rx_irq_en (RW)
  - bit2 tx_done (RO; set at end of stop bit; cleared by CON read or TXD write)
  - bit3 rx_ready (RO)
  - bit4 tx_busy (RO)
  - bit5 rx_overrun (RO; cleared by CON read)
  - bit6 frame_err (RO; cleared by CON read)
  - bits 31:7 read 0
  - A CON write affects only bits 1:0.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready). It is derived from registered state only.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - TXD write in cycle N: tx_busy=1 and uart_tx=0 from edge N+1.
  - Each bit is held exactly CLKS_PER_BIT cycles; data bits go out LSB first. Bit counter runs 0..7.
  - STOP drives 1 for CLKS_PER_BIT cycles. On leaving STOP: tx_busy=0 and tx_done=1 on the same edge.
  - Total frame is 10*CLKS_PER_BIT cycles.
- RX input: uart_rx passes through a 2-flop synchroniser (rx_s) before any use.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: rx_s==0 enters START.
  - START: waits CLKS_PER_BIT/2 cycles (integer division). If rx_s is still 0, go to DATA; otherwise it was a glitch, return to IDLE with no flag change.
  - DATA: samples rx_s every CLKS_PER_BIT cycles, 8 samples, shifted in LSB-first.
  - STOP: samples once after CLKS_PER_BIT.
    - Sample==1: rx_data <= shift register and rx_ready=1. If rx_ready was already 1, rx_overrun=1 and the data is overwritten.
    - Sample==0: frame_err=1; rx_data and rx_ready are unchanged.
  - STOP returns to IDLE immediately, so back-to-back frames are accepted.
- Simultaneous events:
  - RXD read on the same edge that sets rx_ready: the set wins (rx_ready=1).
  - CON read on the same edge that sets tx_done, overrun or frame_err: the set wins.
  - TXD write on the edge tx_done is set (not possible from IDLE): ignored.
- Counters wrap to 0 at CLKS_PER_BIT-1. There is no free-running counter state outside a frame.

Test Plan:
- Reset (CLKS_PER_BIT=4): after reset, uart_tx=1, irq=0, CON read=0, RXD read=0.
- TX: write TXD=0x000000A5 with tx_irq_en=1 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting at edge N+1. tx_busy=1 for 40 cycles, then tx_done=1 and irq=1. A CON read returns 0x05 and clears the flag, so irq=0.
- TX busy: write TXD=0x3C, then TXD=0xFF at cycle 5 -> only 0x3C is transmitted; the frame has no 0xFF bits.
- RX: drive frame 0x5A at 4 cycles/bit with rx_irq_en=1 -> rx_ready=1 and irq=1 after the stop sample. RXD read returns 0x5A, then rx_ready=0 and irq=0.
- RX errors:
  - Two frames 0x11 then 0x22 with no RXD read -> RXD=0x22, CON bit5=1.
  - Frame with stop bit 0 -> CON bit6=1, rx_ready unchanged.
  - A 1-cycle low glitch on uart_rx -> no flag change.
- Reset mid-TX at cycle 15 of a frame -> uart_tx=1 on the next edge, tx_busy=0, tx_done=0.
